cic_dec_ctrl: RTL and testbench

Runtime sequencer for the `cic_dec` decimator. It accepts rate-change requests over a valid/ready handshake and recomputes the output scaling shift for the new rate. It clears and flushes the CIC, then generates the decimation strobe and gates `cic_dec` output valid until the comb section has settled. It sits between the register/config interface and one `cic_dec` instance, in the same `fs` clock domain.

---
 rtl/cic_ctrl_pkg.sv | 26 ++
 rtl/cic_dec_ctrl_gain_calc.sv | 69 ++++++
 rtl/cic_dec_ctrl.sv | 135 +++++++++++++
 tb/tb_cic_dec_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared state encoding, width helpers and rate legality check for the
// cic_dec runtime sequencer.
package cic_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CALC  = 3'd1;
  localparam state_t ST_LOG   = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_RUN   = 3'd4;

  // Width of the (R*M)^N product; one spare bit keeps it overflow-free.
  function automatic int calc_pw(input int n, input int r_max, input int m);
    return n * $clog2(r_max * m) + 1;
  endfunction

  function automatic int calc_sw(input int bin, input int n, input int r_max, input int m);
    return $clog2(bin + calc_pw(n, r_max, m));
  endfunction

  function automatic logic rate_legal(input int rate, input int r_min, input int r_max);
    return (rate >= r_min) && (rate <= r_max);
  endfunction

endpackage

// File: rtl/cic_dec_ctrl_gain_calc.sv
// CIC gain calculator: multiplies (R*M) N times, then priority-encodes
// ceil(log2(P)) into the output cut shift. Result is valid while done=1.
module cic_gain_calc
  import cic_ctrl_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 3,
  parameter int BIN   = 10,
  parameter int COUT  = 16,
  parameter int R_MAX = 1024,
  parameter int RW    = $clog2(R_MAX + 1),
  parameter int SW    = calc_sw(BIN, N, R_MAX, M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] rate,
  output logic          done,
  output logic [SW-1:0] shift_val
);

  localparam int PW = calc_pw(N, R_MAX, M);
  localparam int MW = $clog2(N + 1);

  logic [PW-1:0] rm;
  logic [PW-1:0] p;
  logic [PW-1:0] pm1;
  logic [MW-1:0] mul_cnt;
  logic          active;
  int            lg;
  int            sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rm      <= '0;
      p       <= '0;
      mul_cnt <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      rm      <= PW'(rate) * PW'(M);
      p       <= PW'(1);
      mul_cnt <= '0;
      active  <= 1'b1;
      done    <= 1'b0;
    end else if (active) begin
      p       <= p * rm;
      mul_cnt <= mul_cnt + MW'(1);
      if (mul_cnt == MW'(N - 1)) begin
        active <= 1'b0;
        done   <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  // clog2(P) is the MSB index of P-1 plus one; clamp the shift at zero.
  always_comb begin
    pm1 = p - PW'(1);
    lg  = 0;
    for (int i = 0; i < PW; i++) begin
      if (pm1[i]) lg = i + 1;
    end
    sh        = BIN + lg - COUT;
    shift_val = (sh > 0) ? SW'(sh) : '0;
  end

endmodule

// File: rtl/cic_dec_ctrl.sv
// Runtime rate sequencer for cic_dec: handshake, gain recompute, flush,
// decimation strobe and settle gating. Optional macro: CIC_DEC_CTRL_SAMPLE_CNT_EN.
module cic_dec_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int M         = 2,
  parameter int N         = 3,
  parameter int BIN       = 10,
  parameter int COUT      = 16,
  parameter int R_MIN     = 2,
  parameter int R_MAX     = 1024,
  parameter int FLUSH_CYC = 8,
  parameter int RW        = $clog2(R_MAX + 1),
  parameter int SW        = calc_sw(BIN, N, R_MAX, M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [RW-1:0] cfg_rate,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          cic_clr,
  output logic          dec_stb,
  output logic [SW-1:0] shift,
  input  logic          cic_dval,
  output logic          dval,
  output logic          busy,
  output logic [RW-1:0] rate_cur,
  output logic [31:0]   sample_cnt
);

  localparam int CW  = $clog2(((N > FLUSH_CYC) ? N : FLUSH_CYC) + 1);
  localparam int SCW = $clog2(N * M + 1);

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  phase_cnt;
  logic [RW-1:0]  rate_req;
  logic [RW-1:0]  dec_cnt;
  logic [RW-1:0]  dec_nxt;
  logic [SCW-1:0] settle_cnt;
  logic           legal;
  logic           xfer_ok;
  logic           xfer_bad;
  logic           gain_done;
  logic [SW-1:0]  gain_shift;

  assign legal    = rate_legal(int'(cfg_rate), R_MIN, R_MAX);
  assign xfer_ok  = cfg_valid & cfg_ready & legal;
  assign xfer_bad = cfg_valid & cfg_ready & ~legal;

  cic_gain_calc #(
    .M(M), .N(N), .BIN(BIN), .COUT(COUT), .R_MAX(R_MAX), .RW(RW), .SW(SW)
  ) u_gain (
    .clk      (clk),
    .rst      (rst),
    .start    (xfer_ok),
    .rate     (cfg_rate),
    .done     (gain_done),
    .shift_val(gain_shift)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_RUN: if (xfer_ok) next_state = ST_CALC;
      ST_CALC:  if (phase_cnt == CW'(N - 1)) next_state = ST_LOG;
      ST_LOG:   if (gain_done) next_state = ST_FLUSH;
      ST_FLUSH: if (phase_cnt == CW'(FLUSH_CYC - 1)) next_state = ST_RUN;
      default:  next_state = ST_IDLE;
    endcase
    dec_nxt = (dec_cnt == rate_cur - RW'(1)) ? '0 : dec_cnt + RW'(1);
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      rate_req   <= '0;
      rate_cur   <= '0;
      shift      <= '0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      cic_clr    <= 1'b1;
      busy       <= 1'b0;
      dec_cnt    <= '0;
      dec_stb    <= 1'b0;
      settle_cnt <= '0;
      dval       <= 1'b0;
    end else begin
      state     <= next_state;
      phase_cnt <= (next_state != state) ? '0 : phase_cnt + CW'(1);
      cfg_ready <= (next_state == ST_IDLE) || (next_state == ST_RUN);
      busy      <= (next_state == ST_CALC) || (next_state == ST_LOG) || (next_state == ST_FLUSH);
      cic_clr   <= (next_state != ST_RUN);
      cfg_err   <= xfer_bad;
      if (xfer_ok) rate_req <= cfg_rate;
      if ((state == ST_LOG) && gain_done) shift <= gain_shift;

      if (next_state == ST_RUN) begin
        if (state != ST_RUN) begin
          rate_cur <= rate_req;
          dec_cnt  <= '0;
          dec_stb  <= 1'b0;
        end else begin
          dec_cnt  <= dec_nxt;
          dec_stb  <= (dec_nxt == rate_cur - RW'(1));
        end
      end else begin
        dec_cnt <= '0;
        dec_stb <= 1'b0;
      end

      // The first N*M outputs after each RUN entry carry comb transients.
      if (state == ST_RUN) begin
        dval <= cic_dval && (settle_cnt == SCW'(N * M));
        if (cic_dval && (settle_cnt != SCW'(N * M))) settle_cnt <= settle_cnt + SCW'(1);
      end else begin
        dval       <= 1'b0;
        settle_cnt <= '0;
      end
    end
  end

`ifdef CIC_DEC_CTRL_SAMPLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || xfer_ok) sample_cnt <= '0;
    else if (dval)      sample_cnt <= sample_cnt + 32'd1;
  end
`else
  assign sample_cnt = '0;
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: directed test-plan steps plus random
// traffic, all checked each cycle against a cycle-count behavioural model.
module tb_cic_dec_ctrl;

  localparam int M = 2, N = 3, BIN = 10, COUT = 16;
  localparam int R_MIN = 2, R_MAX = 1024, FLUSH_CYC = 8;
  localparam int RW = 11, SW = 6;
  localparam int RECONF_CYC = N + 1 + FLUSH_CYC;
  localparam int MD_IDLE = 0, MD_RECONF = 1, MD_RUN = 2;
`ifdef CIC_DEC_CTRL_SAMPLE_CNT_EN
  localparam bit SAMPLE_EN = 1'b1;
`else
  localparam bit SAMPLE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [RW-1:0] cfg_rate;
  logic          cfg_ready, cfg_err, cic_clr, dec_stb, cic_dval, dval, busy;
  logic [SW-1:0] shift;
  logic [RW-1:0] rate_cur;
  logic [31:0]   sample_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode plus cycle counts measured from the transfer.
  int          m_mode, m_idx, m_run_cyc, m_pend, m_settle, m_rate_cur, m_shift;
  logic        m_ready, m_err, m_clr, m_stb, m_dval, m_busy;
  logic [31:0] m_samp;

  always #5 clk = ~clk;

  cic_dec_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_rate(cfg_rate),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cic_clr(cic_clr), .dec_stb(dec_stb),
    .shift(shift), .cic_dval(cic_dval), .dval(dval), .busy(busy),
    .rate_cur(rate_cur), .sample_cnt(sample_cnt)
  );

  function automatic int exp_shift(input int r);
    longint p;
    int     l;
    int     s;
    p = 1;
    l = 0;
    for (int i = 0; i < N; i++) p = p * longint'(r * M);
    while ((longint'(1) << l) < p) l++;
    s = BIN + l - COUT;
    return (s < 0) ? 0 : s;
  endfunction

  task automatic modelReset();
    m_mode = MD_IDLE; m_idx = 0; m_run_cyc = 0; m_pend = 0; m_settle = 0;
    m_rate_cur = 0; m_shift = 0; m_samp = '0;
    m_ready = 1'b1; m_err = 1'b0; m_clr = 1'b1; m_stb = 1'b0; m_dval = 1'b0; m_busy = 1'b0;
  endtask

  task automatic modelStep(input logic i_rst, input logic i_valid, input int i_rate, input logic i_dval);
    logic xfer, legal, old_dval;
    if (i_rst) begin
      modelReset();
    end else begin
      xfer     = i_valid && m_ready;
      legal    = (i_rate >= R_MIN) && (i_rate <= R_MAX);
      m_err    = xfer && !legal;
      old_dval = m_dval;
      m_dval   = 1'b0;
      if (m_mode == MD_RUN && i_dval) begin
        if (m_settle >= N * M) m_dval = 1'b1;
        else m_settle++;
      end
      if (xfer && legal) m_samp = '0;
      else m_samp = m_samp + 32'(old_dval);
      if (xfer && legal) begin
        m_mode = MD_RECONF; m_idx = 1; m_pend = i_rate;
      end else if (m_mode == MD_RECONF) begin
        if (m_idx == RECONF_CYC) begin
          m_mode = MD_RUN; m_run_cyc = 1; m_rate_cur = m_pend; m_settle = 0;
        end else begin
          m_idx++;
          if (m_idx == N + 2) m_shift = exp_shift(m_pend);
        end
      end else if (m_mode == MD_RUN) begin
        m_run_cyc++;
      end
      m_ready = (m_mode != MD_RECONF);
      m_busy  = (m_mode == MD_RECONF);
      m_clr   = (m_mode != MD_RUN);
      m_stb   = 1'b0;
      if (m_mode == MD_RUN) m_stb = ((m_run_cyc % m_rate_cur) == 0);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("cfg_ready", 64'(cfg_ready), 64'(m_ready));
    check("cfg_err", 64'(cfg_err), 64'(m_err));
    check("cic_clr", 64'(cic_clr), 64'(m_clr));
    check("dec_stb", 64'(dec_stb), 64'(m_stb));
    check("shift", 64'(shift), 64'(m_shift));
    check("dval", 64'(dval), 64'(m_dval));
    check("busy", 64'(busy), 64'(m_busy));
    check("rate_cur", 64'(rate_cur), 64'(m_rate_cur));
    check("sample_cnt", 64'(sample_cnt), SAMPLE_EN ? 64'(m_samp) : 64'd0);
  endtask

  task automatic applyStimulus(input logic v, input int r, input logic d);
    cfg_valid = v;
    cfg_rate  = RW'(r);
    cic_dval  = d;
  endtask

  task automatic tick();
    logic r, v, d;
    int   rt;
    r = rst; v = cfg_valid; rt = int'(cfg_rate); d = cic_dval;
    @(posedge clk);
    modelStep(r, v, rt, d);
    #1;
    checkOutput();
  endtask

  task automatic configure(input int r);
    applyStimulus(1'b1, r, 1'b0);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
  endtask

  task automatic waitStrobes(input string tag, input int r);
    int k, pulses;
    k = 1; pulses = 0;
    while (pulses < 2 && k < 3 * r + 10) begin
      if (dec_stb) begin
        pulses++;
        if (pulses == 1) check({tag, "_first_stb"}, 64'(k), 64'(r));
        if (pulses == 2) check({tag, "_period"}, 64'(k), 64'(2 * r));
      end
      tick();
      k++;
    end
    check({tag, "_stb_seen"}, 64'(pulses), 64'd2);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_clr"}, 64'(cic_clr), 64'd1);
    check({tag, "_ready"}, 64'(cfg_ready), 64'd1);
    check({tag, "_rate"}, 64'(rate_cur), 64'd0);
    check({tag, "_shift"}, 64'(shift), 64'd0);
    check({tag, "_stb"}, 64'(dec_stb), 64'd0);
    check({tag, "_samp"}, 64'(sample_cnt), 64'd0);
  endtask

  initial begin
    int cnt, k, pulses, rt, sel;
    logic s;
    modelReset();
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;
    tick();

    // R=100: busy window, shift, rate, then strobes with settle gating
    configure(100);
    cnt = 0;
    for (int i = 0; i < RECONF_CYC; i++) begin
      if (busy) cnt++;
      tick();
    end
    check("r100_busy_len", 64'(cnt), 64'd12);
    check("r100_shift", 64'(shift), 64'd17);
    check("r100_rate", 64'(rate_cur), 64'd100);
    check("r100_clr_low", 64'(cic_clr), 64'd0);
    k = 1; pulses = 0;
    while (pulses < 8 && k < 2000) begin
      s = dec_stb;
      if (s) begin
        pulses++;
        if (pulses == 1) check("r100_first_stb", 64'(k), 64'd100);
        if (pulses == 2) check("r100_period", 64'(k), 64'd200);
      end
      applyStimulus(1'b0, 0, s);
      tick();
      if (s && pulses == 6) check("dval_pulse6", 64'(dval), 64'd0);
      if (s && pulses == 7) check("dval_pulse7", 64'(dval), 64'd1);
      k++;
    end
    check("r100_pulses", 64'(pulses), 64'd8);
    applyStimulus(1'b0, 0, 1'b0);

    // Out-of-range requests leave the running configuration untouched
    for (int j = 0; j < 2; j++) begin
      rt = (j == 0) ? 1 : 1025;
      applyStimulus(1'b1, rt, 1'b0);
      tick();
      check($sformatf("err_%0d_pulse", rt), 64'(cfg_err), 64'd1);
      applyStimulus(1'b0, 0, 1'b0);
      tick();
      check($sformatf("err_%0d_clear", rt), 64'(cfg_err), 64'd0);
      check($sformatf("err_%0d_rate", rt), 64'(rate_cur), 64'd100);
      check($sformatf("err_%0d_shift", rt), 64'(shift), 64'd17);
      check($sformatf("err_%0d_clr", rt), 64'(cic_clr), 64'd0);
    end

    // Rate change 100 -> 25 in the same cycle as a strobe
    k = 0;
    while (!dec_stb && k < 200) begin
      tick();
      k++;
    end
    check("r25_stb_found", 64'(dec_stb), 64'd1);
    applyStimulus(1'b1, 25, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 1'b0);
    check("r25_stb_abort", 64'(dec_stb), 64'd0);
    cnt = 0;
    for (int i = 0; i < RECONF_CYC; i++) begin
      if (cic_clr) cnt++;
      tick();
    end
    check("r25_clr_len", 64'(cnt), 64'd12);
    check("r25_shift", 64'(shift), 64'd11);
    check("r25_rate", 64'(rate_cur), 64'd25);
    waitStrobes("r25", 25);

    // Boundary rates
    configure(2);
    repeat (RECONF_CYC) tick();
    check("r2_shift", 64'(shift), 64'd0);
    check("r2_rate", 64'(rate_cur), 64'd2);
    waitStrobes("r2", 2);
    configure(1024);
    repeat (RECONF_CYC) tick();
    check("r1024_shift", 64'(shift), 64'd27);
    check("r1024_rate", 64'(rate_cur), 64'd1024);
    waitStrobes("r1024", 1024);

    // Reset mid-FLUSH and mid-CALC
    configure(10);
    repeat (5) tick();
    check("flush_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    checkResetValues("rst_flush");
    rst = 1'b0;
    repeat (20) tick();
    configure(10);
    tick();
    rst = 1'b1;
    tick();
    checkResetValues("rst_calc");
    rst = 1'b0;
    repeat (20) tick();

    // Sample counting with random cic_dval
    configure(4);
    repeat (RECONF_CYC) tick();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 0, 1'($urandom_range(0, 1)));
      tick();
    end

    // Random traffic: legal/illegal requests, random cic_dval, rare resets
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       rt = $urandom_range(2, 40);
      else if (sel == 7) rt = $urandom_range(0, 1);
      else if (sel == 8) rt = $urandom_range(1025, 2047);
      else               rt = $urandom_range(41, 1024);
      rst = ($urandom_range(0, 1499) == 0);
      applyStimulus($urandom_range(0, 49) == 0, rt, 1'($urandom_range(0, 1)));
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
